// File: rtl/mac_shift_add_mul.sv
// mac_shift_add_mul: 8x8 unsigned shift-and-add multiplier for the MAC datapath.
//
// Handshake: the controller pulses Load_op to capture A/B into the operand
// registers, then pulses Begin_mul (with Load_op low) to start a multiply on
// those captured operands. The multiply takes exactly 8 BUSY edges; End_mul
// then stays high, with product stable, until the controller issues Load_op,
// Begin_mul or RESET_cmd. Begin_mul is ignored while BUSY. Load_op during BUSY
// only refreshes the operand registers; the multiply in flight is unaffected.
// Load_op and Begin_mul at the same edge capture operands only.
module mac_shift_add_mul (
    input  logic        clk,
    input  logic        reset,
    input  logic        RESET_cmd,
    input  logic        Load_op,
    input  logic        Begin_mul,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        End_mul,
    output logic [15:0] product,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state;
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [2:0]  cnt;
    logic [15:0] step_sum;
    logic        start_req;

    // Partial-product sum for the current BUSY edge (never overflows 16 bits).
    always_comb begin
        step_sum = acc + (mplier[0] ? mcand : 16'h0000);
    end

    // A start is honoured only from IDLE or DONE and only without Load_op.
    always_comb begin
        start_req = 1'b0;
        if (Begin_mul && !Load_op && (state == IDLE || state == DONE)) begin
            start_req = 1'b1;
        end
    end

    // Operand capture, multiply datapath and control state, all on one clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            a_reg   <= 8'h00;
            b_reg   <= 8'h00;
            acc     <= 16'h0000;
            mcand   <= 16'h0000;
            mplier  <= 8'h00;
            cnt     <= 3'd0;
            product <= 16'h0000;
        end else if (!RESET_cmd) begin
            // Controller clear: abandon any multiply and wipe all state.
            state   <= IDLE;
            a_reg   <= 8'h00;
            b_reg   <= 8'h00;
            acc     <= 16'h0000;
            mcand   <= 16'h0000;
            mplier  <= 8'h00;
            cnt     <= 3'd0;
            product <= 16'h0000;
        end else begin
            if (Load_op) begin
                a_reg <= A;
                b_reg <= B;
            end
            case (state)
                IDLE: begin
                    if (start_req) begin
                        acc    <= 16'h0000;
                        mcand  <= {8'h00, a_reg};
                        mplier <= b_reg;
                        cnt    <= 3'd0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    // One multiplier bit per edge; Begin_mul/Load_op do not disturb it.
                    acc    <= step_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        product <= step_sum;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (Load_op) begin
                        state <= IDLE;
                    end else if (start_req) begin
                        // Restart with the operands already held in a_reg/b_reg.
                        acc    <= 16'h0000;
                        mcand  <= {8'h00, a_reg};
                        mplier <= b_reg;
                        cnt    <= 3'd0;
                        state  <= BUSY;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Completion flag is a pure decode of the registered state.
    always_comb begin
        End_mul = (state == DONE);
    end

    // State exposed for observation.
    always_comb begin
        dbg_state = state;
    end

endmodule

// File: tb/tb_mac_shift_add_mul.sv
// Directed-plus-random bench for mac_shift_add_mul; expected products come from
// plain A*B arithmetic on the operands the controller last captured.
module tb_mac_shift_add_mul;

    localparam int LATENCY = 8;

    logic        clk;
    logic        reset;
    logic        RESET_cmd;
    logic        Load_op;
    logic        Begin_mul;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        End_mul;
    logic [15:0] product;
    logic [1:0]  dbg_state;

    int checks;
    int errors;
    int edges;
    int begin_edge;

    // Reference model: operands held by the block, expected products queue.
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic [15:0] exp_q[$];
    logic [15:0] last_prod;

    mac_shift_add_mul dut (
        .clk       (clk),
        .reset     (reset),
        .RESET_cmd (RESET_cmd),
        .Load_op   (Load_op),
        .Begin_mul (Begin_mul),
        .A         (A),
        .B         (B),
        .End_mul   (End_mul),
        .product   (product),
        .dbg_state (dbg_state)
    );

    // Clock block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic do_load(input logic [7:0] a, input logic [7:0] b);
        Load_op = 1'b1;
        A = a;
        B = b;
        tick();
        Load_op = 1'b0;
        m_a = a;
        m_b = b;
    endtask

    task automatic do_begin();
        Begin_mul = 1'b1;
        tick();
        Begin_mul = 1'b0;
        begin_edge = edges;
        exp_q.push_back(16'(32'(m_a) * 32'(m_b)));
    endtask

    task automatic wait_done(input string tag);
        int guard;
        logic [15:0] exp;
        guard = 0;
        while (End_mul !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check({tag, "_latency"}, 32'(edges - begin_edge), LATENCY);
        check({tag, "_end_mul"}, 32'(End_mul), 1);
        check({tag, "_product"}, 32'(product), 32'(exp));
        last_prod = exp;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        edges = 0;
        begin_edge = 0;
        m_a = 8'h00;
        m_b = 8'h00;
        last_prod = 16'h0000;
        reset = 1'b0;
        RESET_cmd = 1'b1;
        Load_op = 1'b0;
        Begin_mul = 1'b0;
        A = 8'h00;
        B = 8'h00;

        // Reset state.
        #12;
        check("rst_end_mul", 32'(End_mul), 0);
        check("rst_product", 32'(product), 0);
        check("rst_state_idle", 32'(dbg_state), 0);
        reset = 1'b1;
        repeat (3) tick();
        check("post_rst_no_end", 32'(End_mul), 0);

        // Basic multiply and hold in DONE.
        do_load(8'd13, 8'd11);
        do_begin();
        check("busy_end_low", 32'(End_mul), 0);
        wait_done("m13x11");
        check("m13x11_const", 32'(product), 32'h008F);
        repeat (3) tick();
        check("done_hold_end", 32'(End_mul), 1);
        check("done_hold_prod", 32'(product), 32'h008F);

        // Boundary operands.
        do_load(8'd255, 8'd255); do_begin(); wait_done("m255x255");
        check("m255_const", 32'(product), 32'hFE01);
        do_load(8'd0, 8'd200);   do_begin(); wait_done("m0x200");
        do_load(8'd1, 8'd128);   do_begin(); wait_done("m1x128");

        // Restart from DONE with held operands.
        do_begin();
        check("restart_end_low", 32'(End_mul), 0);
        wait_done("restart");

        // Controller clear at the 4th BUSY edge.
        do_load(8'd9, 8'd9);
        do_begin();
        repeat (3) tick();
        RESET_cmd = 1'b0;
        tick();
        RESET_cmd = 1'b1;
        exp_q.delete();
        m_a = 8'h00;
        m_b = 8'h00;
        check("clr_product", 32'(product), 0);
        check("clr_state_idle", 32'(dbg_state), 0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (End_mul === 1'b1) seen++;
            end
            check("clr_no_end_pulse", 32'(seen), 0);
        end
        do_load(8'd6, 8'd7); do_begin(); wait_done("m6x7");

        // Asynchronous reset mid-BUSY.
        do_load(8'd100, 8'd50);
        do_begin();
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        check("arst_product", 32'(product), 0);
        check("arst_end_mul", 32'(End_mul), 0);
        exp_q.delete();
        m_a = 8'h00;
        m_b = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        repeat (12) tick();
        check("arst_no_end", 32'(End_mul), 0);

        // Begin_mul pulses during BUSY are ignored.
        do_load(8'd200, 8'd3);
        do_begin();
        tick();
        Begin_mul = 1'b1; tick(); Begin_mul = 1'b0;
        tick();
        Begin_mul = 1'b1; tick(); Begin_mul = 1'b0;
        wait_done("busy_begin_ign");

        // Load_op and Begin_mul together: capture only, no start.
        Load_op = 1'b1; Begin_mul = 1'b1; A = 8'd5; B = 8'd5;
        tick();
        Load_op = 1'b0; Begin_mul = 1'b0;
        m_a = 8'd5; m_b = 8'd5;
        check("both_end_low", 32'(End_mul), 0);
        repeat (10) tick();
        check("both_no_start", 32'(End_mul), 0);
        check("both_prod_kept", 32'(product), 32'(last_prod));
        do_begin(); wait_done("m5x5");

        // Load_op during BUSY does not disturb the multiply in flight.
        do_load(8'd10, 8'd20);
        do_begin();
        tick();
        do_load(8'd3, 8'd4);
        wait_done("busy_load_old");
        do_begin(); wait_done("busy_load_new");

        // Controller-style random loop.
        for (int it = 0; it < 10; it++) begin
            do_load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            if (it > 0) check($sformatf("loop%0d_drop", it), 32'(End_mul), 0);
            do_begin();
            wait_done($sformatf("loop%0d", it));
            tick();
        end
        do_load(8'd1, 8'd1);
        check("loop_final_drop", 32'(End_mul), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mac_shift_add_mul.md
MAC_SHIFT_ADD_MUL -- requirements
Module: mac_shift_add_mul

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port RESET_cmd, input, 1 bit: synchronous active-low clear from MAC controller.
REQ-004 SHALL have port Load_op, input, 1 bit: capture operands A and B this cycle.
REQ-005 SHALL have port Begin_mul, input, 1 bit: start multiply on captured operands.
REQ-006 SHALL have port A, input, 8 bits: unsigned multiplicand.
REQ-007 SHALL have port B, input, 8 bits: unsigned multiplier.
REQ-008 SHALL have port End_mul, output, 1 bit: level high while a finished product is held.
REQ-009 SHALL have port product, output, 16 bits: registered unsigned A*B result.

Function
REQ-010 SHALL implement states IDLE, BUSY, DONE; End_mul = (state == DONE), combinational from state only.
REQ-011 SHALL hold operand registers a_reg[7:0] and b_reg[7:0], an accumulator acc[15:0], a shifted multiplicand mcand[15:0], a multiplier shift register mplier[7:0], and an iteration counter cnt[2:0].
REQ-012 SHALL apply per-edge priority: RESET_cmd low > Load_op > Begin_mul > normal progress.
REQ-013 SHALL, on RESET_cmd low at an edge, go to IDLE and zero a_reg, b_reg, acc, product, cnt, mcand and mplier, in any state.
REQ-014 SHALL, on Load_op high at an edge, load a_reg<=A and b_reg<=B; if in DONE, go to IDLE (End_mul low the next cycle); if in IDLE, stay IDLE.
REQ-015 SHALL, on Load_op high while BUSY, update a_reg/b_reg but continue the in-flight multiply on mcand/mplier unchanged.
REQ-016 SHALL, on Begin_mul high with Load_op low in IDLE or DONE, set acc<=0, mcand<={8'h00,a_reg}, mplier<=b_reg, cnt<=0, and go to BUSY.
REQ-017 SHALL ignore Begin_mul while BUSY.
REQ-018 SHALL, on Load_op and Begin_mul high at the same edge, capture operands only and not start.
REQ-019 SHALL, at each BUSY edge, compute acc<=acc+(mplier[0] ? mcand : 0), mcand<=mcand<<1, mplier<=mplier>>1, and cnt<=cnt+1.
REQ-020 SHALL, at the BUSY edge where cnt==7, go to DONE and load product with the final sum, i.e. acc+(mplier[0] ? mcand : 0).
REQ-021 SHALL take exactly 8 BUSY edges, so End_mul is first high after the 8th edge following the edge that sampled Begin_mul.
REQ-022 SHALL perform all arithmetic in 16 bits unsigned, with no overflow possible (max 255*255 = 16'hFE01).
REQ-023 SHALL hold product stable, except under RESET_cmd or reset, from entry to DONE until the next entry to DONE.
REQ-024 SHALL keep product and End_mul unchanged in DONE until Load_op, Begin_mul or RESET_cmd occurs.
REQ-025 SHALL, on Begin_mul in DONE without Load_op, restart using the existing a_reg/b_reg; End_mul goes low the next cycle.
REQ-026 SHALL treat an illegal state encoding as IDLE at the next edge.

Reset
REQ-027 SHALL, on reset low, immediately and asynchronously set state IDLE, End_mul=0, product=16'h0000, and zero all internal registers.
REQ-028 SHALL abandon an operation when reset or RESET_cmd is asserted mid-BUSY, leaving no residual End_mul pulse.
REQ-029 SHALL, after reset deasserts, require Load_op then Begin_mul before any End_mul assertion.

Verification
REQ-030 SHALL pass this scenario: Load_op with A=13, B=11, then Begin_mul -> End_mul high exactly 8 edges after Begin_mul, product=16'h008F.
REQ-031 SHALL pass this scenario: A=255, B=255 -> product=16'hFE01; A=0, B=200 -> product=0, End_mul still at 8 edges; A=1, B=128 -> product=16'h0080.
REQ-032 SHALL pass this scenario: RESET_cmd low at the 4th BUSY edge -> state IDLE, product=0, End_mul never asserts; then Load_op 6, 7 plus Begin_mul -> product=42.
REQ-033 SHALL pass this scenario: reset low mid-BUSY -> outputs zero immediately; Begin_mul pulses during BUSY are ignored without affecting result or timing.
REQ-034 SHALL pass this scenario: a controller-style loop of 10 iterations (Load_op, Begin_mul, wait End_mul, one idle cycle, Load_op) with random operands -> every product matches A*B, and End_mul drops the cycle after each Load_op.
REQ-035 SHALL pass this scenario: Load_op and Begin_mul at the same edge -> no start, End_mul stays low; Load_op during BUSY with new A/B -> current product reflects the old operands.
